mem_responder: RTL and testbench

Data-memory bus responder: the slave end of the core's ram_read/ram_write, busy/ready handshake. Sits between the core's data port and an external asynchronous 16-bit SRAM plus a memory-mapped I/O window. Decodes each request, runs the SRAM cycle with programmable wait states or an I/O handshake with timeout, returns read data and a one-cycle ready pulse. Instruction fetch is out of scope.

---
 rtl/pcpu_mem_pkg.sv | 22 ++
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_wait_counter.sv | 28 ++
 rtl/mem_responder.sv | 133 +++++++++++++
 tb/tb_mem_responder.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcpu_mem_pkg.sv
// Shared definitions for the core data-memory responder: state encoding,
// default address map / timeout, and the latched request record.
package pcpu_mem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SRAM  = 2'd1;
  localparam logic [1:0] ST_IO    = 2'd2;
  localparam logic [1:0] ST_READY = 2'd3;

  localparam int          WAIT_STATES_DEF  = 2;
  localparam logic [15:0] IO_BASE_DEF      = 16'hF000;
  localparam int          IO_TIMEOUT_DEF   = 64;
  localparam logic [15:0] IO_TIMEOUT_RDATA = 16'hFFFF;

  // Request captured in IDLE and held for the whole transfer.
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr;
  } mem_req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Core-side data bus: request strobes and address/data from the core,
// read data and busy/ready handshake back from the responder.
interface mem_responder_if;
  import pcpu_mem_pkg::*;

  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        ram_read;
  logic        ram_write;
  logic [15:0] mem_rdata;
  logic        mem_busy;
  logic        mem_ready;

  modport master (
    output mem_addr, mem_wdata, ram_read, ram_write,
    input  mem_rdata, mem_busy, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, ram_read, ram_write,
    output mem_rdata, mem_busy, mem_ready
  );

endinterface

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that stops at zero; zero flag is combinational.
module mem_wait_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_responder.sv
// Slave end of the core data-memory handshake. Routes each request to the
// external async SRAM (fixed wait states) or the I/O window (ack with
// timeout), returns registered read data and a one-cycle ready pulse.
module mem_responder
  import pcpu_mem_pkg::*;
#(
  parameter int          WAIT_STATES = WAIT_STATES_DEF,
  parameter logic [15:0] IO_BASE     = IO_BASE_DEF,
  parameter int          IO_TIMEOUT  = IO_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus,
  output logic [15:0]     sram_addr,
  output logic [15:0]     sram_wdata,
  input  logic [15:0]     sram_rdata,
  output logic            sram_ce_n,
  output logic            sram_oe_n,
  output logic            sram_we_n,
  output logic [15:0]     io_addr,
  output logic [15:0]     io_wdata,
  input  logic [15:0]     io_rdata,
  output logic            io_rd,
  output logic            io_wr,
  input  logic            io_ack
);

  localparam int             CNT_W   = 8;
  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(IO_TIMEOUT - 1);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  mem_req_t    req;
  logic        take;
  logic        nxt_wr;
  logic        ws_zero;
  logic        to_zero;
  logic [15:0] rdata_r;
  logic        busy_r;
  logic        ready_r;

  assign take   = (state == ST_IDLE) && (bus.ram_read || bus.ram_write);
  // Write wins when both strobes are high.
  assign nxt_wr = take ? bus.ram_write : req.wr;

  mem_wait_counter #(.W(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (take),
    .load_val (WS_LOAD),
    .dec      (state == ST_SRAM),
    .zero     (ws_zero)
  );

  mem_wait_counter #(.W(CNT_W)) u_timeout_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (take),
    .load_val (TO_LOAD),
    .dec      (state == ST_IO),
    .zero     (to_zero)
  );

  // Next-state decode; an ack on the final timeout cycle still counts as success.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (take) state_nxt = (bus.mem_addr >= IO_BASE) ? ST_IO : ST_SRAM;
      ST_SRAM:  if (ws_zero) state_nxt = ST_READY;
      ST_IO:    if (io_ack || to_zero) state_nxt = ST_READY;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State plus strobes registered from the next state so external strobes are glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      io_rd     <= 1'b0;
      io_wr     <= 1'b0;
      busy_r    <= 1'b0;
      ready_r   <= 1'b0;
    end else begin
      state     <= state_nxt;
      sram_ce_n <= !(state_nxt == ST_SRAM);
      sram_oe_n <= !((state_nxt == ST_SRAM) && !nxt_wr);
      sram_we_n <= !((state_nxt == ST_SRAM) && nxt_wr);
      io_rd     <= (state_nxt == ST_IO) && !nxt_wr;
      io_wr     <= (state_nxt == ST_IO) && nxt_wr;
      busy_r    <= (state_nxt == ST_SRAM) || (state_nxt == ST_IO);
      ready_r   <= (state_nxt == ST_READY);
    end
  end

  // Capture the request only in IDLE; it stays on the address/data pins through READY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req <= '0;
    end else if (take) begin
      req <= '{addr: bus.mem_addr, wdata: bus.mem_wdata, wr: bus.ram_write};
    end
  end

  // Read data updates only when a read completes; a timed-out I/O read returns all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_r <= '0;
    end else if (!req.wr) begin
      if ((state == ST_SRAM) && ws_zero) begin
        rdata_r <= sram_rdata;
      end else if (state == ST_IO) begin
        if (io_ack) begin
          rdata_r <= io_rdata;
        end else if (to_zero) begin
          rdata_r <= IO_TIMEOUT_RDATA;
        end
      end
    end
  end

  assign sram_addr     = req.addr;
  assign sram_wdata    = req.wdata;
  assign io_addr       = req.addr;
  assign io_wdata      = req.wdata;
  assign bus.mem_rdata = rdata_r;
  assign bus.mem_busy  = busy_r;
  assign bus.mem_ready = ready_r;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder with a transaction-level reference model.
module tb_mem_responder;
  import pcpu_mem_pkg::*;

  localparam int WS = 2;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if bus();

  logic [15:0] sram_addr, sram_wdata, sram_rdata, io_addr, io_wdata, io_rdata;
  logic        ce_n, oe_n, we_n, io_rd, io_wr;
  logic        io_ack = 1'b0;

  mem_responder #(.WAIT_STATES(WS), .IO_BASE(16'hF000), .IO_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_ce_n  (ce_n),
    .sram_oe_n  (oe_n),
    .sram_we_n  (we_n),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .io_rd      (io_rd),
    .io_wr      (io_wr),
    .io_ack     (io_ack)
  );

  // SRAM device and expected memory contents (256 words, aliased by low byte)
  logic [15:0] dev_mem [256];
  logic [15:0] mdl_mem [256];
  logic [15:0] io_val = 16'h0;

  assign sram_rdata = (!oe_n && !ce_n) ? dev_mem[sram_addr[7:0]] : 16'h5A5A;
  assign io_rdata   = io_val;

  always @(posedge clk) if (!we_n && !ce_n) dev_mem[sram_addr[7:0]] = sram_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction model: the current/last transfer and what preceded it
  bit          t_have = 1'b0;
  int          t_start = 0, t_ready = 0, t_d = 0;
  bit          t_io = 1'b0, t_wr = 1'b0;
  logic [15:0] t_addr = '0, t_wdata = '0, t_rdval = '0;
  logic [15:0] addr_prev = '0, rdata_prev = '0;

  int n_cmp = 0, n_bad = 0;
  int busy_cnt = 0, oe_cnt = 0, we_cnt = 0, ce_cnt = 0, iord_cnt = 0;
  bit ack_win;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // io_ack: exactly on the chosen IO cycle, plus random noise outside any busy window
  always @(posedge clk) begin
    #1;
    ack_win = t_have && (cyc > t_start) && (cyc < t_ready);
    io_ack  = (ack_win && t_io && (t_d != 0) && (cyc == t_start + t_d)) ||
              (!ack_win && ($urandom_range(3) == 0));
  end

  // Called at a negedge while the responder is idle; presents the request.
  task automatic start_txn(input logic [15:0] addr, input logic [15:0] data,
                           input bit rd, input bit wr, input int d, input logic [15:0] ival);
    bit ok;
    if (t_have) begin
      if (!t_wr) rdata_prev = t_rdval;
      addr_prev = t_addr;
    end
    t_have  = 1'b1;
    t_start = cyc;
    t_addr  = addr;
    t_wdata = data;
    t_wr    = wr;
    t_io    = (addr >= 16'hF000);
    t_d     = d;
    io_val  = ival;
    if (t_io) begin
      ok      = (d != 0) && (d <= TO);
      t_ready = cyc + (ok ? d : TO) + 1;
      t_rdval = ok ? ival : 16'hFFFF;
    end else begin
      t_ready = cyc + WS + 1;
      t_rdval = mdl_mem[addr[7:0]];
      if (wr) mdl_mem[addr[7:0]] = data;
    end
    busy_cnt = 0; oe_cnt = 0; we_cnt = 0; ce_cnt = 0; iord_cnt = 0;
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    bus.ram_read  = rd;
    bus.ram_write = wr;
  endtask

  // Returns at the negedge of the ready cycle; drops strobes unless held.
  task automatic finish_txn(input bit hold);
    while (cyc < t_ready) @(negedge clk);
    if (!hold) begin
      bus.ram_read  = 1'b0;
      bus.ram_write = 1'b0;
    end
  endtask

  // Per-cycle comparison of every output against the model
  initial begin
    logic        win, e_rdy;
    logic [15:0] e_addr, e_rdata;
    forever begin
      @(negedge clk);
      #2;
      win     = t_have && (cyc > t_start) && (cyc < t_ready);
      e_rdy   = t_have && (cyc == t_ready);
      e_addr  = (t_have && cyc > t_start) ? t_addr : addr_prev;
      e_rdata = (t_have && !t_wr && cyc >= t_ready) ? t_rdval : rdata_prev;
      chk("busy",      16'(bus.mem_busy),  16'(win));
      chk("ready",     16'(bus.mem_ready), 16'(e_rdy));
      chk("ce_n",      16'(ce_n),  16'(!(win && !t_io)));
      chk("oe_n",      16'(oe_n),  16'(!(win && !t_io && !t_wr)));
      chk("we_n",      16'(we_n),  16'(!(win && !t_io && t_wr)));
      chk("io_rd",     16'(io_rd), 16'(win && t_io && !t_wr));
      chk("io_wr",     16'(io_wr), 16'(win && t_io && t_wr));
      chk("mem_rdata", bus.mem_rdata, e_rdata);
      chk("sram_addr", sram_addr, e_addr);
      chk("io_addr",   io_addr,   e_addr);
      if (win && t_wr && !t_io) chk("sram_wdata", sram_wdata, t_wdata);
      if (win && t_wr && t_io)  chk("io_wdata",   io_wdata,   t_wdata);
      busy_cnt += int'(bus.mem_busy);
      oe_cnt   += int'(!oe_n);
      we_cnt   += int'(!we_n);
      ce_cnt   += int'(!ce_n);
      iord_cnt += int'(io_rd);
    end
  end

  initial begin
    logic [15:0] a, dat, iv;
    int k, d;
    bit hold;
    bus.mem_addr = '0; bus.mem_wdata = '0; bus.ram_read = 1'b0; bus.ram_write = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = 16'($urandom);
      mdl_mem[i] = dev_mem[i];
    end
    dev_mem[8'h23] = 16'hBEEF;
    mdl_mem[8'h23] = 16'hBEEF;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_rdata", bus.mem_rdata, 16'h0000);
    chk("rst_busy",  16'(bus.mem_busy), 16'h0);
    chk("rst_ready", 16'(bus.mem_ready), 16'h0);
    chk("rst_strb",  {13'h0, ce_n, oe_n, we_n}, 16'h0007);
    chk("rst_io",    {14'h0, io_rd, io_wr}, 16'h0000);
    chk("rst_addr",  sram_addr | io_addr, 16'h0000);
    rst = 1'b1;

    // SRAM read
    @(negedge clk);
    start_txn(16'h0123, 16'h0, 1, 0, 0, 16'h0);
    finish_txn(0);
    chk("rd_beef",    bus.mem_rdata, 16'hBEEF);
    chk("rd_busycnt", 16'(busy_cnt), 16'd2);
    chk("rd_oecnt",   16'(oe_cnt), 16'd2);

    // SRAM write with both strobes
    @(negedge clk);
    start_txn(16'h0010, 16'h1234, 1, 1, 0, 16'h0);
    finish_txn(0);
    chk("wr_hold_addr", sram_addr, 16'h0010);
    chk("wr_rdata",     bus.mem_rdata, 16'hBEEF);
    chk("wr_wecnt",     16'(we_cnt), 16'd2);
    chk("wr_oecnt",     16'(oe_cnt), 16'd0);

    // Back-to-back reads, strobe held
    @(negedge clk);
    start_txn(16'h0001, 16'h0, 1, 0, 0, 16'h0);
    finish_txn(1);
    @(negedge clk);
    start_txn(16'h0002, 16'h0, 1, 0, 0, 16'h0);
    finish_txn(0);

    // IO read acked after 3 cycles
    @(negedge clk);
    start_txn(16'hF000, 16'h0, 1, 0, 3, 16'h00A5);
    finish_txn(0);
    chk("io_rdata", bus.mem_rdata, 16'h00A5);
    chk("io_rdcnt", 16'(iord_cnt), 16'd3);

    // Just below the I/O window
    @(negedge clk);
    start_txn(16'hEFFF, 16'h0, 1, 0, 2, 16'h1111);
    finish_txn(0);
    chk("efff_iord", 16'(iord_cnt), 16'd0);
    chk("efff_ce",   16'(ce_cnt), 16'd2);

    // IO timeout
    @(negedge clk);
    start_txn(16'hFFFF, 16'h0, 1, 0, 0, 16'h2222);
    finish_txn(0);
    chk("to_busycnt", 16'(busy_cnt), 16'd64);
    chk("to_rdata",   bus.mem_rdata, 16'hFFFF);

    // Reset during the 2nd cycle of an SRAM write
    @(negedge clk);
    start_txn(16'h0040, 16'hCAFE, 0, 1, 0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    #3;
    rst = 1'b0;
    t_have = 1'b0; addr_prev = '0; rdata_prev = '0;
    #1;
    chk("abort_strb", {13'h0, ce_n, oe_n, we_n}, 16'h0007);
    chk("abort_busy", 16'(bus.mem_busy), 16'h0);
    bus.ram_read = 1'b0; bus.ram_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_txn(16'h0040, 16'h0, 1, 0, 0, 16'h0);
    finish_txn(0);
    chk("post_rst_rd", bus.mem_rdata, 16'hCAFE);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      k = $urandom_range(9);
      if (k < 5)       a = 16'($urandom_range(16'hEFFF));
      else if (k == 5) a = 16'hEFFF;
      else if (k == 6) a = 16'hF000;
      else if (k == 7) a = 16'hFFFF;
      else             a = 16'($urandom_range(16'hFFFF, 16'hF000));
      dat = 16'($urandom);
      iv  = 16'($urandom);
      k = $urandom_range(15);
      if (k == 0)      d = 0;
      else if (k == 1) d = TO;
      else             d = $urandom_range(6, 1);
      case ($urandom_range(2))
        0:       start_txn(a, dat, 1, 0, d, iv);
        1:       start_txn(a, dat, 0, 1, d, iv);
        default: start_txn(a, dat, 1, 1, d, iv);
      endcase
      hold = ($urandom_range(3) == 0);
      finish_txn(hold);
      if (!hold) repeat ($urandom_range(2)) @(negedge clk);
    end
    bus.ram_read = 1'b0; bus.ram_write = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
